pe_mac_dbuf: RTL and testbench
==============================

# pe_mac_dbuf

Parametrised, registered systolic-array processing element for the Gemmini mesh, and the next generation of the HazardFlow PE. It supports output-stationary (OS) and weight-stationary (WS) dataflows. Two accumulator registers (c1/c2) are double-buffered and swapped by the propagate bit. The c output uses a rounding shift followed by saturation. A dataflow-capability check drives a real `bad_dataflow` flag. All outputs are registered, so a mesh of these tiles is pipelined one cycle per hop.

## Interface
- `A_W`, 8: signed width of `a` (input type).
- `OUT_W`, 20: signed width of `b`, `d` and `c` (output type).
- `C_W`, 32: signed width of the c1/c2 accumulators; must be ≥ `OUT_W` and ≥ 2·`A_W`.
- `SHIFT_W`, 5: width of the shift amount.
- `ID_W`, 3: width of `id`.
- `DF`, 2: supported dataflows; 0 = OS only, 1 = WS only, 2 = both.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: qualifies the input transaction.
- `in_a` in `A_W`: row operand.
- `in_b` in `OUT_W`: column operand in OS; partial sum in WS.
- `in_d` in `OUT_W`: preload value.
- `in_dataflow` in 1: 0 = OS, 1 = WS.
- `in_propagate` in 1: selects which of c1/c2 is active.
- `in_shift` in `SHIFT_W`: output shift, applied only on a flip.
- `in_id` in `ID_W`, `in_last` in 1: tags, passed through.
- `out_valid`, `out_a`, `out_b`, `out_c`, `out_dataflow`, `out_propagate`, `out_shift`, `out_id`, `out_last` out: registered results.
- `bad_dataflow` out 1: the transaction requested an unsupported dataflow.

## Operation
- State: c1 and c2 (`C_W`), plus `last_prop` (1 bit). All state updates only when `in_valid` = 1 and the dataflow is supported.
- flip = `in_propagate` ≠ `last_prop`. The applied shift is s = flip ? `in_shift` : 0. `last_prop` is then updated to `in_propagate`.
- OS, `in_propagate` = 1:
  - out_c = rsat(c1, s); out_b = `in_b`.
  - c2 ← c2 + `in_a`·`in_b`[A_W-1:0], both operands signed.
  - c1 ← sext(`in_d`).
- OS, `in_propagate` = 0: same as above with c1 and c2 swapped.
- WS, `in_propagate` = 1:
  - out_c = c1[OUT_W-1:0] (no shift); out_b = `in_b` + `in_a`·c2[A_W-1:0], wrapping mod 2^`OUT_W`.
  - c1 ← sext(`in_d`).
- WS, `in_propagate` = 0: same as above with c1 and c2 swapped.
- Accumulation wraps mod 2^`C_W`.
- rsat(x, s):
  - s = 0: x unchanged.
  - s > 0: (x + 2^(s-1)) >>> s, an arithmetic shift with round-half-up.
  - The result saturates to [−2^(`OUT_W`-1), 2^(`OUT_W`-1)−1].
- `out_a`, `out_dataflow`, `out_propagate`, `out_shift`, `out_id`, `out_last` are the registered input values.
- Unsupported dataflow (`DF` = 0 with WS requested, or `DF` = 1 with OS requested) while `in_valid` = 1:
  - `bad_dataflow` = 1 and `out_valid` = 1 in the next cycle.
  - `out_c` = 0, `out_b` = `in_b`.
  - c1, c2 and `last_prop` are unchanged.
- `in_valid` = 0: state holds; the output registers capture as normal with `out_valid` = 0 and `bad_dataflow` = 0.

## Timing
- Latency is 1 cycle from input to every output. Throughput is one transaction per cycle. There is no backpressure.
- Reset (asynchronous, any cycle, including mid-accumulation): c1, c2, `last_prop` and every output go to 0 immediately. The first valid input after reset with `in_propagate` = 1 counts as a flip.
- Back-to-back flips are legal. Each flip reads the buffer that was filled up to the previous cycle.
- The shift is sampled only on a flip cycle. `in_shift` on a non-flip cycle is ignored for `out_c`, but is still passed through on `out_shift`.

## Structure
- Package `pe_pkg` holds:
  - dataflow encodings `DF_OS` = 0 and `DF_WS` = 1;
  - capability codes `DF_OS_ONLY`, `DF_WS_ONLY`, `DF_BOTH`;
  - the default widths.
- Sub-module `pe_round_sat` (combinational): parameters `C_W`, `OUT_W`, `SHIFT_W`; implements rsat.
- The top level contains the state registers, the OS/WS datapath multiplexing, and the output register stage.

## Test plan
- Reset: assert `rst` for 2 cycles → every output is 0. Then valid OS, prop = 1, shift = 0 → `out_c` = 0 (c1 was 0).
- OS accumulate (`last_prop` = 0, c1 = c2 = 0):
  - prop=0, a=3, b=4, d=7 → `out_c`=0; c1=12, c2=7.
  - prop=0, a=2, b=5 → `out_c`=7; c1=22.
  - prop=1, shift=1, d=0 → `out_c`=11, `out_propagate`=1.
- Rounding: c1=5 then flip with shift=1 → `out_c`=3. c1=−5 then flip with shift=1 → `out_c`=−2.
- Saturation: 64 OS MACs of a=−128, b=−128 (c=1,048,576), then flip with shift=0 → `out_c`=524287. With a=−128, b=127 instead → `out_c`=−524288.
- WS: prop=0, d=6 (loads c2=6), then prop=1, a=3, b=10 → `out_b`=28. `in_valid`=0 gap cycles in between → `out_valid`=0 and c2 remains 6.
- `DF`=0 with a WS request:
  - `bad_dataflow`=1 for exactly 1 cycle, `out_c`=0, `out_b`=`in_b`.
  - The next OS flip returns the pre-error c value.
  - `rst` asserted mid-sequence clears everything within the same cycle.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: dataflow encodings, capability codes and default widths for the PE
package pe_pkg;
  typedef enum logic {DF_OS = 1'b0, DF_WS = 1'b1} dataflow_e;
  typedef enum int {DF_OS_ONLY = 0, DF_WS_ONLY = 1, DF_BOTH = 2} df_cap_e;
  localparam int DEF_A_W = 8;
  localparam int DEF_OUT_W = 20;
  localparam int DEF_C_W = 32;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_ID_W = 3;
endpackage

// File: rtl/pe_round_sat.sv
// pe_round_sat: round-half-up arithmetic right shift followed by saturation to OUT_W
module pe_round_sat #(
  parameter int C_W = 32,
  parameter int OUT_W = 20,
  parameter int SHIFT_W = 5
) (
  input  logic signed [C_W-1:0]   x,
  input  logic        [SHIFT_W-1:0] s,
  output logic signed [OUT_W-1:0] y
);
  localparam logic signed [C_W:0] MAX = {{(C_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [C_W:0] MIN = ~MAX;
  logic signed [C_W:0] r, q;
  // one guard bit keeps the rounding add from overflowing
  always_comb begin
    r = $signed({x[C_W-1], x}) + (s == '0 ? '0 : {{C_W{1'b0}}, 1'b1} << (s - 1'b1));
    q = r >>> s;
    y = q > MAX ? MAX[OUT_W-1:0] : q < MIN ? MIN[OUT_W-1:0] : q[OUT_W-1:0];
  end
endmodule

// File: rtl/pe_mac_dbuf.sv
// pe_mac_dbuf: registered OS/WS systolic PE with double-buffered accumulators
module pe_mac_dbuf
  import pe_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int C_W = DEF_C_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int ID_W = DEF_ID_W,
  parameter int DF = DF_BOTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [OUT_W-1:0] in_b,
  input  logic signed [OUT_W-1:0] in_d,
  input  logic                 in_dataflow,
  input  logic                 in_propagate,
  input  logic [SHIFT_W-1:0]   in_shift,
  input  logic [ID_W-1:0]      in_id,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic signed [A_W-1:0]   out_a,
  output logic signed [OUT_W-1:0] out_b,
  output logic signed [OUT_W-1:0] out_c,
  output logic                 out_dataflow,
  output logic                 out_propagate,
  output logic [SHIFT_W-1:0]   out_shift,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_last,
  output logic                 bad_dataflow
);
  logic signed [C_W-1:0] c1, c2, act, acc, d_x, prod_x;
  logic signed [2*A_W-1:0] prod, wprod;
  logic signed [A_W-1:0] bl, wt;
  logic signed [OUT_W-1:0] c_rs, c_nx, b_nx;
  logic [SHIFT_W-1:0] s;
  logic last_prop, ws, ok, upd, flip;
  // act is the buffer drained to out_c and reloaded from d; acc accumulates (OS) or holds the weight (WS)
  always_comb begin
    ws = in_dataflow == DF_WS;
    ok = ws ? DF != DF_OS_ONLY : DF != DF_WS_ONLY;
    upd = in_valid && ok;
    flip = in_propagate != last_prop;
    s = flip ? in_shift : '0;
    act = in_propagate ? c1 : c2;
    acc = in_propagate ? c2 : c1;
    bl = in_b[A_W-1:0];
    wt = acc[A_W-1:0];
    prod = in_a * bl;
    wprod = in_a * wt;
    prod_x = C_W'(prod);
    d_x = C_W'(in_d);
    c_nx = !ok ? '0 : ws ? act[OUT_W-1:0] : c_rs;
    b_nx = ok && ws ? in_b + OUT_W'(wprod) : in_b;
  end
  pe_round_sat #(.C_W(C_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rs (.x(act), .s(s), .y(c_rs));
  // accumulator state moves only on supported valid transactions
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c1 <= '0;
      c2 <= '0;
      last_prop <= 1'b0;
    end else if (upd) begin
      last_prop <= in_propagate;
      if (in_propagate) begin
        c1 <= d_x;
        if (!ws) c2 <= c2 + prod_x;
      end else begin
        c2 <= d_x;
        if (!ws) c1 <= c1 + prod_x;
      end
    end
  // output stage captures every cycle so a mesh advances one hop per clock
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_c <= '0;
      out_dataflow <= 1'b0;
      out_propagate <= 1'b0;
      out_shift <= '0;
      out_id <= '0;
      out_last <= 1'b0;
      bad_dataflow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_a <= in_a;
      out_b <= b_nx;
      out_c <= c_nx;
      out_dataflow <= in_dataflow;
      out_propagate <= in_propagate;
      out_shift <= in_shift;
      out_id <= in_id;
      out_last <= in_last;
      bad_dataflow <= in_valid && !ok;
    end
endmodule

// File: tb/tb_pe_mac_dbuf.sv
// tb_pe_mac_dbuf: scoreboard bench for pe_mac_dbuf (DF=2 main instance, DF=0 capability instance)
module tb_pe_mac_dbuf;
  logic clk = 0, rst = 0, in_valid = 0, v0 = 0, in_dataflow = 0, in_propagate = 0, in_last = 0;
  logic signed [7:0] in_a = 0;
  logic signed [19:0] in_b = 0, in_d = 0;
  logic [4:0] in_shift = 0;
  logic [2:0] in_id = 0;
  logic out_valid, out_dataflow, out_propagate, out_last, bad_dataflow;
  logic signed [7:0] out_a;
  logic signed [19:0] out_b, out_c;
  logic [4:0] out_shift;
  logic [2:0] out_id;
  logic out_valid0, out_dataflow0, out_propagate0, out_last0, bad_dataflow0;
  logic signed [7:0] out_a0;
  logic signed [19:0] out_b0, out_c0;
  logic [4:0] out_shift0;
  logic [2:0] out_id0;
  typedef struct {
    bit v; bit bad; logic [19:0] b; logic [19:0] c; logic [7:0] a;
    bit df; bit prop; logic [4:0] sh; logic [2:0] id; bit last;
  } exp_t;
  exp_t q[$], q0[$];
  longint m1[2], m2[2];
  bit mlp[2];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pe_mac_dbuf #(.DF(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_dataflow(in_dataflow), .in_propagate(in_propagate), .in_shift(in_shift), .in_id(in_id),
    .in_last(in_last), .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_dataflow(out_dataflow), .out_propagate(out_propagate), .out_shift(out_shift),
    .out_id(out_id), .out_last(out_last), .bad_dataflow(bad_dataflow));
  pe_mac_dbuf #(.DF(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_dataflow(in_dataflow), .in_propagate(in_propagate), .in_shift(in_shift), .in_id(in_id),
    .in_last(in_last), .out_valid(out_valid0), .out_a(out_a0), .out_b(out_b0), .out_c(out_c0),
    .out_dataflow(out_dataflow0), .out_propagate(out_propagate0), .out_shift(out_shift0),
    .out_id(out_id0), .out_last(out_last0), .bad_dataflow(bad_dataflow0));
  function automatic longint rsat_m(input longint x, input int s);
    longint y;
    y = s == 0 ? x : (x + (longint'(1) << (s - 1))) >>> s;
    return y > 524287 ? 524287 : y < -524288 ? -524288 : y;
  endfunction
  task automatic predict(input int k, input int cap, input bit v, output exp_t e);
    bit ws, ok, flip;
    int s;
    longint act, w, ai, bl, t;
    byte wl, bb;
    ws = in_dataflow;
    ok = ws ? cap != 0 : cap != 1;
    flip = in_propagate != mlp[k];
    s = flip ? int'(in_shift) : 0;
    act = in_propagate ? m1[k] : m2[k];
    w = in_propagate ? m2[k] : m1[k];
    ai = in_a;
    bb = in_b[7:0];
    bl = bb;
    wl = w[7:0];
    e.v = v; e.bad = v && !ok; e.a = in_a; e.df = in_dataflow; e.prop = in_propagate;
    e.sh = in_shift; e.id = in_id; e.last = in_last;
    t = ws && ok ? longint'(in_b) + ai * longint'(wl) : longint'(in_b);
    e.b = t[19:0];
    t = !ok ? 0 : ws ? act : rsat_m(act, s);
    e.c = t[19:0];
    if (v && ok) begin
      mlp[k] = in_propagate;
      if (in_propagate) begin
        if (!ws) m2[k] = longint'(int'(m2[k] + ai * bl));
        m1[k] = in_d;
      end else begin
        if (!ws) m1[k] = longint'(int'(m1[k] + ai * bl));
        m2[k] = in_d;
      end
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m1[k] = 0; m2[k] = 0; mlp[k] = 0; end
    q.delete();
    q0.delete();
  endtask
  task automatic apply_reset();
    in_valid = 0; v0 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 model_reset();
  endtask
  task automatic step(input bit v, input bit vz, input bit df, input bit prop,
                      input logic signed [7:0] a, input logic signed [19:0] b,
                      input logic signed [19:0] d, input logic [4:0] sh);
    exp_t e;
    rst = 0;
    in_valid = v; v0 = vz; in_dataflow = df; in_propagate = prop;
    in_a = a; in_b = b; in_d = d; in_shift = sh;
    in_id = 3'($urandom); in_last = 1'($urandom);
    predict(0, 2, v, e); q.push_back(e);
    predict(1, 0, vz, e); q0.push_back(e);
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    exp_t e, e0;
    in_a = 8'sd55; in_b = 20'sd77; in_id = 3'd5; in_last = 1; in_valid = 1;
    @(posedge clk); #1;
    apply_reset();
    n_chk++; if ({out_valid, out_a, out_b, out_c, out_dataflow, out_propagate, out_shift, out_id, out_last, bad_dataflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%0b a=%0d b=%0d c=%0d id=%0d want all 0", out_valid, out_a, out_b, out_c, out_id); end
    step(1, 0, 0, 1, 8'sd0, 20'sd0, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'sd0 || out_c !== e.c) begin n_fail++; $display("FAIL reset_first_flip_c: got %0d want 0", out_c); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_valid: got %0b want 1", out_valid); end
  endtask
  task automatic test_os_accumulate();
    exp_t e, e0;
    apply_reset();
    step(1, 0, 0, 0, 8'sd3, 20'sd4, 20'sd7, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'sd0 || out_c !== e.c) begin n_fail++; $display("FAIL os_acc1_c: got %0d want 0", out_c); end
    step(1, 0, 0, 0, 8'sd2, 20'sd5, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'sd7 || out_c !== e.c) begin n_fail++; $display("FAIL os_acc2_c: got %0d want 7", out_c); end
    step(1, 0, 0, 1, 8'sd0, 20'sd0, 20'sd0, 5'd1);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'sd11 || out_c !== e.c) begin n_fail++; $display("FAIL os_flip_c: got %0d want 11", out_c); end
    n_chk++; if (out_propagate !== 1'b1) begin n_fail++; $display("FAIL os_flip_prop: got %0b want 1", out_propagate); end
    n_chk++; if (out_b !== e.b) begin n_fail++; $display("FAIL os_flip_b: got %0d want %0d", out_b, e.b); end
  endtask
  task automatic test_rounding();
    exp_t e, e0;
    apply_reset();
    step(1, 0, 0, 0, 8'sd5, 20'sd1, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    step(1, 0, 0, 1, 8'sd0, 20'sd0, 20'sd0, 5'd1);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'sd3 || out_c !== e.c) begin n_fail++; $display("FAIL round_pos: got %0d want 3", out_c); end
    apply_reset();
    step(1, 0, 0, 1, -8'sd5, 20'sd1, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    step(1, 0, 0, 0, 8'sd0, 20'sd0, 20'sd0, 5'd1);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== -20'sd2 || out_c !== e.c) begin n_fail++; $display("FAIL round_neg: got %0d want -2", out_c); end
    step(1, 0, 0, 0, 8'sd0, 20'sd0, 20'sd0, 5'd3);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== e.c) begin n_fail++; $display("FAIL shift_ignored_noflip: got %0d want %0d", out_c, e.c); end
    n_chk++; if (out_shift !== 5'd3) begin n_fail++; $display("FAIL shift_passthrough: got %0d want 3", out_shift); end
  endtask
  task automatic test_saturation();
    exp_t e, e0;
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 0, 0, -8'sd128, -20'sd128, 20'sd0, 5'd0);
      e = q.pop_front(); e0 = q0.pop_front();
    end
    step(1, 0, 0, 1, 8'sd0, 20'sd0, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'sd524287 || out_c !== e.c) begin n_fail++; $display("FAIL sat_pos: got %0d want 524287", out_c); end
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 0, 0, -8'sd128, 20'sd127, 20'sd0, 5'd0);
      e = q.pop_front(); e0 = q0.pop_front();
    end
    step(1, 0, 0, 1, 8'sd0, 20'sd0, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c !== 20'h80000 || out_c !== e.c) begin n_fail++; $display("FAIL sat_neg: got %0d want -524288", out_c); end
  endtask
  task automatic test_ws();
    exp_t e, e0;
    apply_reset();
    step(1, 0, 1, 0, 8'sd0, 20'sd0, 20'sd6, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 1, 8'sd9, 20'sd3, 20'sd100, 5'd2);
      e = q.pop_front(); e0 = q0.pop_front();
      n_chk++; if (out_valid !== 1'b0 || bad_dataflow !== 1'b0) begin n_fail++; $display("FAIL ws_gap: got v=%0b bad=%0b want 0 0", out_valid, bad_dataflow); end
    end
    step(1, 0, 1, 1, 8'sd3, 20'sd10, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_b !== 20'sd28 || out_b !== e.b) begin n_fail++; $display("FAIL ws_b: got %0d want 28", out_b); end
    n_chk++; if (out_c !== e.c) begin n_fail++; $display("FAIL ws_c: got %0d want %0d", out_c, e.c); end
  endtask
  task automatic test_bad_dataflow();
    exp_t e, e0;
    apply_reset();
    step(0, 1, 0, 0, 8'sd3, 20'sd4, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    step(0, 1, 1, 1, 8'sd5, 20'sd99, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (bad_dataflow0 !== 1'b1 || out_valid0 !== 1'b1 || e0.bad !== 1'b1) begin n_fail++; $display("FAIL bad_flag: got bad=%0b v=%0b want 1 1", bad_dataflow0, out_valid0); end
    n_chk++; if (out_c0 !== 20'sd0 || out_b0 !== 20'sd99) begin n_fail++; $display("FAIL bad_outs: got c=%0d b=%0d want 0 99", out_c0, out_b0); end
    step(0, 1, 0, 1, 8'sd0, 20'sd0, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (bad_dataflow0 !== 1'b0) begin n_fail++; $display("FAIL bad_one_cycle: got %0b want 0", bad_dataflow0); end
    n_chk++; if (out_c0 !== 20'sd12 || out_c0 !== e0.c) begin n_fail++; $display("FAIL bad_state_kept: got %0d want 12", out_c0); end
    step(0, 1, 0, 1, 8'sd2, 20'sd2, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    #2 rst = 1;
    #1;
    n_chk++; if ({out_valid0, out_a0, out_b0, out_c0, bad_dataflow0, out_propagate0, out_a} !== '0) begin
      n_fail++; $display("FAIL async_reset: got v=%0b a=%0d b=%0d c=%0d want all 0", out_valid0, out_a0, out_b0, out_c0); end
    @(posedge clk); #1;
    model_reset();
    step(0, 1, 0, 0, 8'sd0, 20'sd0, 20'sd0, 5'd0);
    e = q.pop_front(); e0 = q0.pop_front();
    n_chk++; if (out_c0 !== 20'sd0 || out_c0 !== e0.c) begin n_fail++; $display("FAIL reset_clears_c2: got %0d want 0", out_c0); end
  endtask
  task automatic test_random();
    exp_t e, e0;
    bit p;
    apply_reset();
    p = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) p = ~p;
      step($urandom_range(4) != 0, 0, 1'($urandom), p, 8'($urandom), 20'($urandom), 20'($urandom), 5'($urandom));
      e = q.pop_front(); e0 = q0.pop_front();
      n_chk++; if ({out_valid, bad_dataflow, out_c, out_b} !== {e.v, e.bad, e.c, e.b}) begin
        n_fail++; $display("FAIL rand_data[%0d]: got v=%0b c=%0d b=%0d want v=%0b c=%0d b=%0d", i, out_valid, out_c, out_b, e.v, $signed(e.c), $signed(e.b)); end
      n_chk++; if ({out_a, out_dataflow, out_propagate, out_shift, out_id, out_last} !== {e.a, e.df, e.prop, e.sh, e.id, e.last}) begin
        n_fail++; $display("FAIL rand_pass[%0d]: got a=%0d sh=%0d id=%0d want a=%0d sh=%0d id=%0d", i, out_a, out_shift, out_id, $signed(e.a), e.sh, e.id); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_os_accumulate();
    test_rounding();
    test_saturation();
    test_ws();
    test_bad_dataflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
